// File: rtl/pipe_imem_loader_pkg.sv
// Shared constants and types for the UART instruction-memory loader.
package pipe_imem_loader_pkg;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam int unsigned CSUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4
  } loader_state_e;

  // Running modulo-256 sum of the data bytes.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0] data_byte);
    return acc + data_byte;
  endfunction

endpackage

// File: rtl/pipe_imem_loader_word_pack.sv
// Packs little-endian bytes into 32-bit words; the packed word and its
// ready pulse appear the cycle after the fourth byte is accepted.
module loader_word_pack (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_idx_o,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q;
  logic [31:0] shift_q;
  logic        ready_q;
  logic [31:0] word_q;

  // Byte index, shift assembler and completed-word register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      idx_q   <= 2'd0;
      shift_q <= 32'h0;
      ready_q <= 1'b0;
      word_q  <= 32'h0;
    end else if (clear_i) begin
      // A partial word is thrown away; the last written word stays visible.
      idx_q   <= 2'd0;
      shift_q <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= byte_valid_i && (idx_q == 2'd3);
      if (byte_valid_i) begin
        shift_q <= {byte_i, shift_q[31:8]};
        idx_q   <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          word_q <= {byte_i, shift_q[31:8]};
        end else begin
          word_q <= word_q;
        end
      end else begin
        shift_q <= shift_q;
        idx_q   <= idx_q;
      end
    end
  end

  assign byte_idx_o   = idx_q;
  assign word_ready_o = ready_q;
  assign word_o       = word_q;

endmodule

// File: rtl/pipe_imem_loader.sv
// Receives a framed byte stream from the UART, writes the packed words into
// instruction RAM and holds the CPU while the frame is in flight.
module pipe_imem_loader
  import pipe_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err,
  output logic [15:0]       word_cnt
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;

  loader_state_e      state_q;
  logic [7:0]         cnt_lo_q;
  logic [15:0]        count_q;
  logic [CSUM_W-1:0]  csum_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               hold_q;
  logic               ok_q;
  logic               err_q;
  logic [15:0]        word_cnt_q;

  logic               timeout_hit;
  logic               pack_valid;
  logic               pack_clear;
  logic [1:0]         byte_idx;
  logic [15:0]        count_in;

  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);
  assign pack_valid  = rx_valid && (state_q == ST_DATA) && !timeout_hit;
  assign pack_clear  = timeout_hit || !resetn;
  assign count_in    = {rx_data, cnt_lo_q};

  loader_word_pack u_pack (
    .clock        (clock),
    .resetn       (resetn),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_i       (rx_data),
    .byte_idx_o   (byte_idx),
    .word_ready_o (imem_we),
    .word_o       (imem_wdata)
  );

  // Frame FSM with its timeout counter and all registered status outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_lo_q   <= 8'h00;
      count_q    <= 16'h0000;
      csum_q     <= '0;
      to_cnt_q   <= '0;
      addr_q     <= '0;
      hold_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= 16'h0000;
    end else if (timeout_hit) begin
      // Timeout wins over any byte arriving in the same cycle.
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      hold_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b1;
    end else begin
      if (state_q == ST_IDLE || rx_valid) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      if (rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == LOADER_MAGIC) begin
              state_q    <= ST_CNT_LO;
              hold_q     <= 1'b1;
              ok_q       <= 1'b0;
              err_q      <= 1'b0;
              word_cnt_q <= 16'h0000;
              csum_q     <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_CNT_LO: begin
            cnt_lo_q <= rx_data;
            state_q  <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            count_q <= count_in;
            if ({1'b0, count_in} > MAX_WORDS) begin
              state_q <= ST_IDLE;
              hold_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (count_in == 16'h0000) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum_q <= csum_add(csum_q, rx_data);
            if (byte_idx == 2'd3) begin
              addr_q     <= word_cnt_q[ADDR_W-1:0];
              word_cnt_q <= word_cnt_q + 16'd1;
              if (word_cnt_q + 16'd1 == count_q) begin
                state_q <= ST_CSUM;
              end else begin
                state_q <= ST_DATA;
              end
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_CSUM: begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            if (rx_data == csum_q) begin
              ok_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign imem_addr = addr_q;
  assign cpu_hold  = hold_q;
  assign load_ok   = ok_q;
  assign load_err  = err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_pipe_imem_loader.sv
// Directed bench for pipe_imem_loader with hand-computed expectations.
module tb_pipe_imem_loader;

  localparam int ADDR_W = 6;
  localparam int TO_CYC = 100;

  logic              clock;
  logic              resetn;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_ok;
  logic              load_err;
  logic [15:0]       word_cnt;

  int checks;
  int failures;
  int n_writes;
  int base;

  pipe_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_ok    (load_ok),
    .load_err   (load_err),
    .word_cnt   (word_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count RAM writes, sampled mid-cycle.
  always @(negedge clock) begin
    if (imem_we === 1'b1) n_writes <= n_writes + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the capturing posedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(imem_we),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_wdata"}, imem_wdata,      32'd0);
    check({tag, "_hold"},  32'(cpu_hold),   32'd0);
    check({tag, "_ok"},    32'(load_ok),    32'd0);
    check({tag, "_err"},   32'(load_err),   32'd0);
    check({tag, "_wcnt"},  32'(word_cnt),   32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_writes = 0;
    resetn   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    resetn = 1'b1;

    // Good two-word frame, bytes back-to-back.
    base = n_writes;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    check("t1_hold_mid", 32'(cpu_hold), 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h01); send_byte(8'h20);
    check("t1_we0",    32'(imem_we),   32'd1);
    check("t1_addr0",  32'(imem_addr), 32'd0);
    check("t1_data0",  imem_wdata,     32'h20010013);
    check("t1_wcnt1",  32'(word_cnt),  32'd1);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    check("t1_we1",    32'(imem_we),   32'd1);
    check("t1_addr1",  32'(imem_addr), 32'd1);
    check("t1_data1",  imem_wdata,     32'h08000008);
    send_byte(8'h44);
    check("t1_ok",     32'(load_ok),   32'd1);
    check("t1_err",    32'(load_err),  32'd0);
    check("t1_wcnt",   32'(word_cnt),  32'd2);
    check("t1_hold",   32'(cpu_hold),  32'd0);
    check("t1_we_off", 32'(imem_we),   32'd0);
    check("t1_data_hold", imem_wdata,  32'h08000008);
    @(negedge clock);
    check("t1_nwr",    32'(n_writes - base), 32'd2);

    // Same frame with a wrong checksum.
    base = n_writes;
    send_gap(8'hA5);
    check("t2_ok_clr", 32'(load_ok), 32'd0);
    send_gap(8'h02); send_gap(8'h00);
    send_gap(8'h13); send_gap(8'h00); send_gap(8'h01); send_gap(8'h20);
    send_gap(8'h08); send_gap(8'h00); send_gap(8'h00); send_gap(8'h08);
    send_gap(8'h45);
    check("t2_err",  32'(load_err), 32'd1);
    check("t2_ok",   32'(load_ok),  32'd0);
    check("t2_hold", 32'(cpu_hold), 32'd0);
    check("t2_nwr",  32'(n_writes - base), 32'd2);

    // Count 65 exceeds a 64-word RAM.
    base = n_writes;
    send_gap(8'hA5);
    check("t3_err_clr", 32'(load_err), 32'd0);
    send_gap(8'h41);
    send_byte(8'h00);
    check("t3_err",  32'(load_err), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd0);
    send_gap(8'h11);
    check("t3_nwr",  32'(n_writes - base), 32'd0);
    check("t3_idle_hold", 32'(cpu_hold), 32'd0);

    // Partial word then silence: timeout on the 100th idle edge.
    base = n_writes;
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00); send_gap(8'h11);
    send_byte(8'h22);
    repeat (99) @(negedge clock);
    check("t4_hold_pre", 32'(cpu_hold), 32'd1);
    check("t4_err_pre",  32'(load_err), 32'd0);
    @(negedge clock);
    check("t4_hold", 32'(cpu_hold), 32'd0);
    check("t4_err",  32'(load_err), 32'd1);
    check("t4_nwr",  32'(n_writes - base), 32'd0);
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00);
    send_gap(8'hAA); send_gap(8'hBB); send_gap(8'hCC); send_byte(8'hDD);
    check("t4b_addr", 32'(imem_addr), 32'd0);
    check("t4b_data", imem_wdata,     32'hDDCCBBAA);
    send_gap(8'h0E);
    check("t4b_ok",  32'(load_ok),  32'd1);
    check("t4b_err", 32'(load_err), 32'd0);
    check("t4b_nwr", 32'(n_writes - base), 32'd1);

    // Noise then a zero-word frame.
    base = n_writes;
    send_gap(8'h00); send_gap(8'hFF); send_gap(8'h5A);
    check("t5_noise_hold", 32'(cpu_hold), 32'd0);
    send_gap(8'hA5); send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
    check("t5_ok",   32'(load_ok),  32'd1);
    check("t5_wcnt", 32'(word_cnt), 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_nwr",  32'(n_writes - base), 32'd0);

    // Reset after the fifth data byte of a two-word frame.
    base = n_writes;
    send_gap(8'hA5); send_gap(8'h02); send_gap(8'h00);
    send_gap(8'h01); send_gap(8'h02); send_gap(8'h03); send_gap(8'h04);
    send_byte(8'h05);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check_all_zero("t6_rst");
    check("t6_nwr", 32'(n_writes - base), 32'd1);
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00);
    send_gap(8'h10); send_gap(8'h20); send_gap(8'h30); send_byte(8'h40);
    check("t6b_data", imem_wdata, 32'h40302010);
    send_gap(8'hA0);
    check("t6b_ok",   32'(load_ok),  32'd1);
    check("t6b_wcnt", 32'(word_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
